// File: rtl/mem_execute_pkg.sv
// ============================================================================
// Module  : mem_execute_pkg
// Brief   : Shared core types: opcodes, memory-op encoding, LSU FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_execute_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_op_t;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t c_st_idle = 2'd0;
    localparam mem_state_t c_st_req  = 2'd1;
    localparam mem_state_t c_st_wb   = 2'd2;
    localparam mem_state_t c_st_err  = 2'd3;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Alignment is judged on the natural size of the access, not the bus width.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] ea_lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return ea_lo[0];
            MEM_LW, MEM_SW:          return (ea_lo != 2'b00);
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_execute_align.sv
// ============================================================================
// Module  : mem_align
// Brief   : Lane extraction/extension of load data, byte enables and
//           replicated write data for stores.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
    import mem_execute_pkg::*;
#(
    parameter int DW = 32
) (
    input  mem_op_t                     i_op,
    input  logic [$clog2(DW/8)-1:0]     i_lane,
    input  logic [31:0]                 i_store_data,
    input  logic [DW-1:0]               i_rdata,
    output logic [DW/8-1:0]             o_byte_en,
    output logic [DW-1:0]               o_wdata,
    output logic [31:0]                 o_load_data
);

    localparam int c_nb = DW / 8;
    localparam logic [c_nb-1:0] c_be_b = c_nb'(4'h1);
    localparam logic [c_nb-1:0] c_be_h = c_nb'(4'h3);
    localparam logic [c_nb-1:0] c_be_w = c_nb'(4'hF);

    logic [DW-1:0] w_shifted;

    // Bring the addressed lane down to bit 0 so extraction is lane-agnostic.
    assign w_shifted = i_rdata >> {i_lane, 3'b000};

    always_comb begin
        o_byte_en   = '0;
        o_wdata     = '0;
        o_load_data = '0;
        case (i_op)
            MEM_LB:  o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_LH:  o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_LW:  o_load_data = w_shifted[31:0];
            MEM_LBU: o_load_data = {24'b0, w_shifted[7:0]};
            MEM_LHU: o_load_data = {16'b0, w_shifted[15:0]};
            MEM_SB: begin
                o_byte_en = c_be_b << i_lane;
                o_wdata   = {(DW/8){i_store_data[7:0]}};
            end
            MEM_SH: begin
                o_byte_en = c_be_h << i_lane;
                o_wdata   = {(DW/16){i_store_data[15:0]}};
            end
            MEM_SW: begin
                o_byte_en = c_be_w << i_lane;
                o_wdata   = {(DW/32){i_store_data}};
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_execute.sv
// ============================================================================
// Module  : mem_execute
// Brief   : Load/store execute stage: EA calc, LSU handshake with timeout,
//           load write-back and misalignment reporting.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_execute
    import mem_execute_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    input  logic              i_stall,
    input  logic              i_valid,
    input  mem_op_t           i_memop,
    input  logic [31:0]       i_rs1_val,
    input  logic [31:0]       i_rs2_val,
    input  logic [31:0]       i_imm,
    input  logic [4:0]        i_rd,
    output logic              o_busy,
    output logic              o_lsu_read,
    output logic              o_lsu_write,
    output logic [AW-1:0]     o_lsu_addr,
    output logic [DW/8-1:0]   o_lsu_byte_en,
    output logic [DW-1:0]     o_lsu_wdata,
    input  logic [DW-1:0]     i_lsu_rdata,
    input  logic              i_lsu_ack,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd,
    output logic [31:0]       o_wb_data,
    output logic              o_store_done,
    output logic              o_misalign,
    output logic              o_timeout
);

    localparam int          c_lane_w   = $clog2(DW/8);
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    mem_state_t       r_state;
    mem_op_t          r_op;
    logic [AW-1:0]    r_ea;
    logic [4:0]       r_rd;
    logic [31:0]      r_store_data;
    logic [15:0]      r_tmo_cnt;
    logic             r_lsu_read;
    logic             r_lsu_write;
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    logic [31:0]      r_wb_data;
    logic             r_store_done;
    logic             r_misalign;
    logic             r_timeout;

    logic [31:0]      w_sum;
    logic [AW-1:0]    w_ea;
    logic [DW/8-1:0]  w_byte_en;
    logic [DW-1:0]    w_wdata;
    logic [31:0]      w_load_data;

    assign w_sum = i_rs1_val + i_imm;

    generate
        if (AW <= 32) begin : g_ea_trunc
            assign w_ea = w_sum[AW-1:0];
        end else begin : g_ea_ext
            assign w_ea = {{(AW-32){1'b0}}, w_sum};
        end
    endgenerate

    // Lane formatting works from captured request state so LSU outputs stay
    // stable for the whole request.
    mem_align #(.DW(DW)) u_align (
        .i_op         (r_op),
        .i_lane       (r_ea[c_lane_w-1:0]),
        .i_store_data (r_store_data),
        .i_rdata      (i_lsu_rdata),
        .o_byte_en    (w_byte_en),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    assign o_busy        = (r_state != c_st_idle);
    assign o_lsu_read    = r_lsu_read;
    assign o_lsu_write   = r_lsu_write;
    assign o_lsu_addr    = {r_ea[AW-1:c_lane_w], {c_lane_w{1'b0}}};
    assign o_lsu_byte_en = w_byte_en;
    assign o_lsu_wdata   = w_wdata;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_rd       = r_wb_rd;
    assign o_wb_data     = r_wb_data;
    assign o_store_done  = r_store_done;
    assign o_misalign    = r_misalign;
    assign o_timeout     = r_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= c_st_idle;
            r_op         <= MEM_LB;
            r_ea         <= '0;
            r_rd         <= '0;
            r_store_data <= '0;
            r_tmo_cnt    <= '0;
            r_lsu_read   <= 1'b0;
            r_lsu_write  <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_store_done <= 1'b0;
            r_misalign   <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (i_clk_en) begin
            r_store_done <= 1'b0;
            r_misalign   <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (i_valid && !i_stall) begin
                        r_op         <= i_memop;
                        r_ea         <= w_ea;
                        r_rd         <= i_rd;
                        r_store_data <= i_rs2_val;
                        r_tmo_cnt    <= '0;
                        if (is_misaligned(i_memop, w_ea[1:0])) begin
                            r_state    <= c_st_err;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state     <= c_st_req;
                            r_lsu_read  <= !is_store(i_memop);
                            r_lsu_write <= is_store(i_memop);
                        end
                    end
                end
                c_st_req: begin
                    // Ack takes precedence over an expiring timeout.
                    if (i_lsu_ack) begin
                        r_lsu_read  <= 1'b0;
                        r_lsu_write <= 1'b0;
                        if (is_store(r_op)) begin
                            r_store_done <= 1'b1;
                            r_state      <= c_st_idle;
                        end else if (r_rd != 5'd0) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= w_load_data;
                            r_state    <= c_st_wb;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        r_lsu_read  <= 1'b0;
                        r_lsu_write <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_state     <= c_st_idle;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                c_st_wb: begin
                    if (!i_stall) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_execute.sv
// ============================================================================
// Module  : tb_mem_execute
// Brief   : Scoreboard bench for mem_execute at DW=32 and DW=64.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_execute;
    import mem_execute_pkg::*;

    localparam int c_ev_wb = 0;
    localparam int c_ev_st = 1;
    localparam int c_ev_ma = 2;
    localparam int c_ev_to = 3;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst, clk_en, stall, valid, ack, sel;
    mem_op_t     memop;
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd;
    logic [63:0] rdata;

    logic        b32, r32, w32, wbv32, sd32, ma32, to32;
    logic [31:0] a32, wd32, wbd32;
    logic [3:0]  be32;
    logic [4:0]  wbrd32;
    logic        b64, r64, w64, wbv64, sd64, ma64, to64;
    logic [31:0] a64, wbd64;
    logic [63:0] wd64;
    logic [7:0]  be64;
    logic [4:0]  wbrd64;

    logic        m_busy, m_rd, m_wr, m_wbv, m_sd, m_ma, m_to;
    logic [31:0] m_addr, m_wbd;
    logic [63:0] m_wd;
    logic [7:0]  m_be;
    logic [4:0]  m_wbrd;

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t exp_q[$];
    logic prev_wbv = 1'b0;

    always #5 clk = ~clk;

    mem_execute #(.AW(32), .DW(32), .TIMEOUT(4)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_stall(stall),
        .i_valid(valid && !sel), .i_memop(memop), .i_rs1_val(rs1),
        .i_rs2_val(rs2), .i_imm(imm), .i_rd(rd), .o_busy(b32),
        .o_lsu_read(r32), .o_lsu_write(w32), .o_lsu_addr(a32),
        .o_lsu_byte_en(be32), .o_lsu_wdata(wd32), .i_lsu_rdata(rdata[31:0]),
        .i_lsu_ack(ack && !sel), .o_wb_valid(wbv32), .o_wb_rd(wbrd32),
        .o_wb_data(wbd32), .o_store_done(sd32), .o_misalign(ma32),
        .o_timeout(to32)
    );

    mem_execute #(.AW(32), .DW(64)) u_dut64 (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_stall(stall),
        .i_valid(valid && sel), .i_memop(memop), .i_rs1_val(rs1),
        .i_rs2_val(rs2), .i_imm(imm), .i_rd(rd), .o_busy(b64),
        .o_lsu_read(r64), .o_lsu_write(w64), .o_lsu_addr(a64),
        .o_lsu_byte_en(be64), .o_lsu_wdata(wd64), .i_lsu_rdata(rdata),
        .i_lsu_ack(ack && sel), .o_wb_valid(wbv64), .o_wb_rd(wbrd64),
        .o_wb_data(wbd64), .o_store_done(sd64), .o_misalign(ma64),
        .o_timeout(to64)
    );

    always_comb begin
        if (sel) begin
            {m_busy, m_rd, m_wr, m_wbv, m_sd, m_ma, m_to} = {b64, r64, w64, wbv64, sd64, ma64, to64};
            m_addr = a64; m_wbd = wbd64; m_wd = wd64; m_be = be64; m_wbrd = wbrd64;
        end else begin
            {m_busy, m_rd, m_wr, m_wbv, m_sd, m_ma, m_to} = {b32, r32, w32, wbv32, sd32, ma32, to32};
            m_addr = a32; m_wbd = wbd32; m_wd = {32'b0, wd32}; m_be = {4'b0, be32}; m_wbrd = wbrd32;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic sb_event(input int kind, input logic [63:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", 64'(kind), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", 64'(kind), 64'(e.kind));
            check("sb_val", val, e.val);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [63:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] wb_val(input logic [4:0] r, input logic [31:0] d);
        return {27'b0, r, d};
    endfunction

    // Completion monitor: every status event or write-back start is scored.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_wbv && !prev_wbv) sb_event(c_ev_wb, wb_val(m_wbrd, m_wbd));
            if (m_sd) sb_event(c_ev_st, 64'd0);
            if (m_ma) sb_event(c_ev_ma, 64'd0);
            if (m_to) sb_event(c_ev_to, 64'd0);
        end
        prev_wbv <= m_wbv;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input mem_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d, input logic [4:0] r);
        int n;
        n = 0;
        sel = s;
        #1;
        while (m_busy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("issue_wait_timeout", 64'd1, 64'd0);
        memop = op; rs1 = a; imm = b; rs2 = d; rd = r;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_ack(input logic [63:0] data);
        rdata = data;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1; stall = 1'b0; valid = 1'b0; ack = 1'b0; sel = 1'b0;
        memop = MEM_LB; rs1 = '0; rs2 = '0; imm = '0; rd = '0; rdata = '0;
        repeat (3) tick();
        check("rst_busy32", 64'(b32), 64'd0);
        check("rst_strobes32", 64'({r32, w32}), 64'd0);
        check("rst_addr32", 64'(a32), 64'd0);
        check("rst_be_wd32", {28'b0, be32, wd32}, 64'd0);
        check("rst_wb32", {27'b0, wbv32, wbd32, 4'b0}, 64'd0);
        check("rst_pulses32", 64'({sd32, ma32, to32}), 64'd0);
        check("rst_busy64", 64'({b64, r64, w64, wbv64}), 64'd0);
        check("rst_wd64", wd64, 64'd0);
        rst = 1'b0;
        tick();

        // LW at 0x104, ack on the third request cycle
        expect_ev(c_ev_wb, wb_val(5'd5, 32'hDEADBEEF));
        issue(1'b0, MEM_LW, 32'h100, 32'd4, 32'd0, 5'd5);
        check("lw_read", 64'({m_rd, m_wr}), 64'd2);
        check("lw_addr", 64'(m_addr), 64'h104);
        check("lw_be", 64'(m_be), 64'd0);
        tick();
        check("lw_read_c2", 64'(m_rd), 64'd1);
        tick();
        check("lw_read_c3", 64'(m_rd), 64'd1);
        do_ack(64'hDEADBEEF);
        check("lw_wbv", 64'(m_wbv), 64'd1);
        check("lw_read_dropped", 64'(m_rd), 64'd0);
        tick();
        check("lw_wbv_one_cycle", 64'({m_wbv, m_busy}), 64'd0);

        // DW=64 byte loads from lane 7, ack in first request cycle
        expect_ev(c_ev_wb, wb_val(5'd3, 32'hFFFFFF80));
        issue(1'b1, MEM_LB, 32'h1000, 32'd7, 32'd0, 5'd3);
        check("lb64_addr", 64'(m_addr), 64'h1000);
        check("lb64_be", 64'(m_be), 64'd0);
        do_ack(64'h80112233_44556677);
        check("lb64_min_latency", 64'(m_wbv), 64'd1);
        tick();
        expect_ev(c_ev_wb, wb_val(5'd3, 32'h00000080));
        issue(1'b1, MEM_LBU, 32'h1000, 32'd7, 32'd0, 5'd3);
        do_ack(64'h80112233_44556677);
        tick();

        // DW=64 SB at lane 5
        expect_ev(c_ev_st, 64'd0);
        issue(1'b1, MEM_SB, 32'h2000, 32'd5, 32'h0000005A, 5'd1);
        check("sb64_strobes", 64'({m_rd, m_wr}), 64'd1);
        check("sb64_be", 64'(m_be), 64'h20);
        check("sb64_wd", m_wd, 64'h5A5A5A5A_5A5A5A5A);
        do_ack(64'd0);
        check("sb64_done", 64'({m_sd, m_busy}), 64'd2);
        tick();
        check("sb64_done_pulse", 64'(m_sd), 64'd0);

        // DW=32 SH at 0x2002
        expect_ev(c_ev_st, 64'd0);
        issue(1'b0, MEM_SH, 32'h2000, 32'd2, 32'hABCD1234, 5'd0);
        check("sh_addr", 64'(m_addr), 64'h2000);
        check("sh_be", 64'(m_be), 64'h0C);
        check("sh_wd", m_wd, 64'h12341234);
        tick();
        do_ack(64'd0);
        check("sh_done", 64'(m_sd), 64'd1);
        tick();

        // Misaligned LW
        expect_ev(c_ev_ma, 64'd0);
        issue(1'b0, MEM_LW, 32'h3000, 32'd1, 32'd0, 5'd6);
        check("ma_no_strobe", 64'({m_rd, m_wr}), 64'd0);
        check("ma_pulse_busy", 64'({m_ma, m_busy}), 64'd3);
        tick();
        check("ma_end", 64'({m_ma, m_busy, m_wbv}), 64'd0);

        // Timeout after 4 request cycles
        expect_ev(c_ev_to, 64'd0);
        issue(1'b0, MEM_LW, 32'h400, 32'd0, 32'd0, 5'd7);
        for (int i = 0; i < 4; i++) begin
            check("to_read_held", 64'({m_rd, m_to}), 64'd2);
            tick();
        end
        check("to_fired", 64'({m_rd, m_to, m_busy}), 64'd2);
        tick();

        // Ack in the fourth cycle beats the timeout
        expect_ev(c_ev_wb, wb_val(5'd7, 32'h11223344));
        issue(1'b0, MEM_LW, 32'h400, 32'd0, 32'd0, 5'd7);
        repeat (3) tick();
        do_ack(64'h11223344);
        check("to_ack_wins", 64'({m_wbv, m_to}), 64'd2);
        tick();

        // LH lane 2 with stall through WB
        expect_ev(c_ev_wb, wb_val(5'd9, 32'hFFFFF00D));
        issue(1'b0, MEM_LH, 32'h500, 32'd2, 32'd0, 5'd9);
        stall = 1'b1;
        do_ack(64'hF00D0000);
        for (int i = 0; i < 3; i++) begin
            check("wb_stall_hold", wb_val(m_wbrd, m_wbd) | {31'b0, m_wbv, 32'b0}, {31'b0, 1'b1, 32'b0} | wb_val(5'd9, 32'hFFFFF00D));
            tick();
        end
        stall = 1'b0;
        check("wb_stall_4th", 64'({m_wbv, m_wbd}), {31'b0, 1'b1, 32'hFFFFF00D});
        tick();
        check("wb_stall_exit", 64'({m_wbv, m_busy}), 64'd0);

        // rd = 0 suppresses write-back
        issue(1'b0, MEM_LW, 32'h700, 32'd0, 32'd0, 5'd0);
        check("rd0_read", 64'(m_rd), 64'd1);
        do_ack(64'h99999999);
        check("rd0_no_wb", 64'({m_wbv, m_busy}), 64'd0);

        // Clock enable low freezes the request
        expect_ev(c_ev_wb, wb_val(5'd10, 32'hCAFEF00D));
        issue(1'b0, MEM_LW, 32'h800, 32'd0, 32'd0, 5'd10);
        clk_en = 1'b0; ack = 1'b1; rdata = 64'hCAFEF00D;
        tick();
        tick();
        check("ce_frozen", 64'({m_rd, m_busy, m_wbv}), 64'd6);
        ack = 1'b0; clk_en = 1'b1;
        do_ack(64'hCAFEF00D);
        check("ce_resume_wb", 64'(m_wbv), 64'd1);
        tick();

        // Stray ack while idle
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle_ack_ignored", 64'({m_busy, m_wbv, m_sd}), 64'd0);

        // Reset mid-request
        issue(1'b0, MEM_SW, 32'h600, 32'd0, 32'h55, 5'd1);
        check("rstreq_write", 64'({m_wr, m_be}), 64'h10F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstreq_abandon", 64'({m_wr, m_rd, m_busy, m_sd, m_to}), 64'd0);
        tick();
        tick();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_execute.md
MEM_EXECUTE -- requirements
Module: mem_execute

Interface
REQ-001 Parameter AW, default 32, LSU byte-address width.
REQ-002 Parameter DW, default 32, LSU data width; legal values 32 and 64.
REQ-003 Parameter TIMEOUT, default 255, max cycles a request waits for ack; range 1..65535.
REQ-004 i_clk  in  1  the single clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_clk_en  in  1  state advances only when high.
REQ-007 i_stall  in  1  pipeline stall; blocks accept and holds write-back.
REQ-008 i_valid  in  1  memory op presented.
REQ-009 i_memop  in  MemOp  LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-010 i_rs1_val, i_rs2_val, i_imm  in  32 each  base, store data, offset.
REQ-011 i_rd  in  5  load destination register.
REQ-012 o_busy  out  1  high whenever state is not IDLE.
REQ-013 o_lsu_read, o_lsu_write  out  1 each  request strobes, never both high.
REQ-014 o_lsu_addr  out  AW  DW/8-aligned address.
REQ-015 o_lsu_byte_en  out  DW/8  write lane enables.
REQ-016 o_lsu_wdata  out  DW  write data.
REQ-017 i_lsu_rdata  in  DW  read data, valid with ack.
REQ-018 i_lsu_ack  in  1  completes the current request.
REQ-019 o_wb_valid  out  1, o_wb_rd  out  5, o_wb_data  out  32  load result.
REQ-020 o_store_done, o_misalign, o_timeout  out  1 each  single-cycle status pulses.

Function
REQ-021 EA = i_rs1_val + i_imm modulo 2^32, truncated to AW bits; overflow wraps silently.
REQ-022 Accept only in IDLE with i_valid & ~i_stall & i_clk_en; EA, op, rd, store data are registered on accept.
REQ-023 FSM states: IDLE, REQ, WB, ERR.
REQ-024 IDLE->ERR when accepted op is misaligned (half with EA[0]=1; word with EA[1:0]!=0); no LSU request is issued.
REQ-025 IDLE->REQ otherwise; o_lsu_read (loads) or o_lsu_write (stores) asserts the cycle after accept and holds stable until ack or timeout.
REQ-026 Lane = EA[log2(DW/8)-1:0]; byte_en = 1/3/F (SB/SH/SW) shifted left by lane; wdata = store data replicated across all lanes.
REQ-027 Loads drive o_lsu_byte_en = 0.
REQ-028 REQ with i_lsu_ack: load -> capture lane-extracted data, sign-extend (LB, LH) or zero-extend (LBU, LHU, LW), go WB; store -> pulse o_store_done, go IDLE.
REQ-029 Ack in the first REQ cycle is legal; minimum latency accept-to-o_wb_valid is 2 cycles.
REQ-030 Timeout counter clears on REQ entry, increments each enabled REQ cycle without ack; when it reaches TIMEOUT, drop strobe, pulse o_timeout, go IDLE.
REQ-031 Ack and timeout in the same cycle: ack wins.
REQ-032 WB: o_wb_valid high, o_wb_rd/o_wb_data stable; leave to IDLE on the first enabled cycle with ~i_stall.
REQ-033 i_rd = 0: access performed, o_wb_valid suppressed, WB skipped.
REQ-034 ERR: pulse o_misalign one cycle, return to IDLE.
REQ-035 i_stall in REQ does not cancel or pause an issued request.
REQ-036 i_clk_en low freezes all state, counters and outputs.
REQ-037 i_lsu_ack outside REQ is ignored.

Reset
REQ-038 On i_rst: state IDLE, counter 0, all outputs 0, captured registers 0; takes priority over i_clk_en.
REQ-039 Reset mid-REQ abandons the request; strobes low after that edge, no status pulse.

Structure
REQ-040 MemOp enum and FSM state typedef live in the shared core package beside Opcode.
REQ-041 One combinational sub-module, mem_align, performs lane extraction/extension and byte_en/wdata formation.

Verification
REQ-042 DW=32: rs1=0x100, imm=4, LW, ack after 3 cycles with 0xDEADBEEF -> addr 0x104, wb_data 0xDEADBEEF, wb_valid 1 cycle.
REQ-043 DW=64: LB at EA 0x1007, rdata byte7=0x80 -> addr 0x1000, wb_data 0xFFFFFF80; LBU -> 0x00000080.
REQ-044 SH at EA 0x2002, rs2=0x1234, DW=32 -> byte_en 4'b1100, wdata 0x12341234, o_store_done on ack.
REQ-045 LW at EA 0x3001 -> no strobe, o_misalign one cycle, no wb.
REQ-046 TIMEOUT=4, never ack -> read held 4 cycles, o_timeout pulse, IDLE; ack on cycle 4 instead -> normal completion.
REQ-047 Stall held during WB for 3 cycles -> wb outputs stable 4 cycles; reset mid-REQ -> strobes 0 after edge.
